// File: rtl/sad_accum_pkg.sv
// sad_accum_pkg: shared FSM state encoding and counter-width helper for the SAD engine
package sad_accum_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int npairs);
    return $clog2(npairs + 1);
  endfunction
endpackage

// File: rtl/sad_accum_4b_dpath.sv
// sad_accum_4b_dpath: |a-b| datapath and sum register; SAD_ACCUM_SATURATE_EN selects saturating add with ovf
module sad_accum_4b_dpath #(
  parameter int SUM_NBITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           a,
  input  logic [3:0]           b,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 acc,
`ifdef SAD_ACCUM_SATURATE_EN
  output logic                 ovf,
`endif
  output logic [SUM_NBITS-1:0] sum
);
  logic [3:0]           ad;
  logic [SUM_NBITS-1:0] ext;
  logic [SUM_NBITS-1:0] nxt;
  assign ad  = (a > b) ? a - b : b - a;
  assign ext = SUM_NBITS'(ad);
`ifdef SAD_ACCUM_SATURATE_EN
  logic [SUM_NBITS:0] wide;
  assign wide = {1'b0, sum} + {1'b0, ext};
  assign nxt  = wide[SUM_NBITS] ? '1 : wide[SUM_NBITS-1:0];
  // Sticky overflow flag for the current frame; the first pair never saturates
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (clr || load) ovf <= 1'b0;
    else if (acc) ovf <= ovf | wide[SUM_NBITS];
`else
  assign nxt = sum + ext;
`endif
  // Sum register: clear on result consumption, load on first pair, accumulate after
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (clr) sum <= '0;
    else if (load) sum <= ext;
    else if (acc) sum <= nxt;
endmodule

// File: rtl/sad_accum_4b.sv
// sad_accum_4b: sequential SAD engine over NPAIRS operand pairs; optional SAD_ACCUM_SATURATE_EN adds saturation and ovf
module sad_accum_4b
  import sad_accum_pkg::*;
#(
  parameter int NPAIRS    = 4,
  parameter int SUM_NBITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [3:0]           in0,
  input  logic [3:0]           in1,
  output logic                 out_val,
  input  logic                 out_rdy,
`ifdef SAD_ACCUM_SATURATE_EN
  output logic                 ovf,
`endif
  output logic [SUM_NBITS-1:0] out_sum
);
  localparam int CW = cnt_w(NPAIRS);
  localparam logic [CW-1:0] LAST = CW'(NPAIRS - 1);
  state_t        state, nxt;
  logic [CW-1:0] count;
  logic          load, acc, clr;
  assign load = in_val && in_rdy && state == IDLE;
  assign acc  = in_val && in_rdy && state == ACCUM;
  assign clr  = out_val && out_rdy;
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // Next state and Moore handshake outputs; unused encoding falls back to IDLE
  always_comb begin
    nxt     = (state == ACCUM || state == DONE) ? state : IDLE;
    in_rdy  = state != DONE;
    out_val = state == DONE;
    if (load) nxt = (NPAIRS == 1) ? DONE : ACCUM;
    if (acc && count == LAST) nxt = DONE;
    if (clr) nxt = IDLE;
  end
  // Pairs accepted so far in this frame
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (load) count <= CW'(1);
    else if (acc) count <= count + CW'(1);
  sad_accum_4b_dpath #(.SUM_NBITS(SUM_NBITS)) u_dpath (
    .clk  (clk),
    .rst  (rst),
    .a    (in0),
    .b    (in1),
    .clr  (clr),
    .load (load),
    .acc  (acc),
`ifdef SAD_ACCUM_SATURATE_EN
    .ovf  (ovf),
`endif
    .sum  (out_sum)
  );
endmodule

// File: tb/tb_sad_accum_4b.sv
// tb_sad_accum_4b: directed bench for sad_accum_4b (default widths plus a 5-bit sum instance for wrap/saturate)
module tb_sad_accum_4b;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_val = 1'b0;
  logic       out_rdy = 1'b1;
  logic [3:0] in0 = '0;
  logic [3:0] in1 = '0;
  logic       in_rdy, out_val, in_rdy5, out_val5;
  logic [7:0] out_sum;
  logic [4:0] out_sum5;
  int tests = 0;
  int fails = 0;
`ifdef SAD_ACCUM_SATURATE_EN
  logic ovf, ovf5;
`endif

  always #5 clk = ~clk;

  sad_accum_4b #(.NPAIRS(4), .SUM_NBITS(8)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in0(in0), .in1(in1),
    .out_val(out_val), .out_rdy(out_rdy),
`ifdef SAD_ACCUM_SATURATE_EN
    .ovf(ovf),
`endif
    .out_sum(out_sum));

  sad_accum_4b #(.NPAIRS(4), .SUM_NBITS(5)) dut5 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy5), .in0(in0), .in1(in1),
    .out_val(out_val5), .out_rdy(out_rdy),
`ifdef SAD_ACCUM_SATURATE_EN
    .ovf(ovf5),
`endif
    .out_sum(out_sum5));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b);
    in0 = a;
    in1 = b;
    in_val = 1'b1;
    chk("in_rdy_send", 16'(in_rdy), 16'd1);
    tick();
    in_val = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b0;
    tick();
    chk("idle_in_rdy", 16'(in_rdy), 16'd1);
    chk("idle_out_val", 16'(out_val), 16'd0);
    // partial frame then asynchronous reset between clock edges
    send(4'd3, 4'd9);
    send(4'd9, 4'd3);
    chk("partial_no_val", 16'(out_val), 16'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_sum", 16'(out_sum), 16'd0);
    chk("rst_out_val", 16'(out_val), 16'd0);
    chk("rst_in_rdy", 16'(in_rdy), 16'd1);
    #1 rst = 1'b0;
    tick();
    // reset mid-frame: no carry-over, 4 x |2-5| = 12
    for (int i = 0; i < 4; i++) send(4'd2, 4'd5);
    chk("post_rst_val", 16'(out_val), 16'd1);
    chk("post_rst_sum", 16'(out_sum), 16'd12);
    tick();
    chk("post_rst_idle", 16'(in_rdy), 16'd1);
    // basic back-to-back frame: 6+6+15+0 = 27
    send(4'd3, 4'd9);
    send(4'd9, 4'd3);
    send(4'd0, 4'd15);
    chk("basic_not_done", 16'(out_val), 16'd0);
    send(4'd7, 4'd7);
    chk("basic_val", 16'(out_val), 16'd1);
    chk("basic_sum", 16'(out_sum), 16'd27);
    chk("basic_rdy_low", 16'(in_rdy), 16'd0);
`ifdef SAD_ACCUM_SATURATE_EN
    chk("basic_ovf", 16'(ovf), 16'd0);
`endif
    tick();
    chk("basic_idle_val", 16'(out_val), 16'd0);
    chk("basic_idle_rdy", 16'(in_rdy), 16'd1);
    chk("basic_cleared", 16'(out_sum), 16'd0);
    // bubbles and backpressure
    out_rdy = 1'b0;
    send(4'd3, 4'd9);
    tick();
    chk("bub_rdy", 16'(in_rdy), 16'd1);
    tick();
    chk("bub_sum", 16'(out_sum), 16'd6);
    send(4'd9, 4'd3);
    tick();
    tick();
    send(4'd0, 4'd15);
    tick();
    tick();
    chk("bub_no_val", 16'(out_val), 16'd0);
    send(4'd7, 4'd7);
    in_val = 1'b1;
    in0 = 4'd15;
    in1 = 4'd0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_val", 16'(out_val), 16'd1);
      chk("bp_sum", 16'(out_sum), 16'd27);
      chk("bp_rdy_low", 16'(in_rdy), 16'd0);
      tick();
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    tick();
    chk("bp_consumed", 16'(out_val), 16'd0);
    chk("bp_cleared", 16'(out_sum), 16'd0);
    // back-to-back frames: 4 then 60
    for (int i = 0; i < 4; i++) send(4'd1, 4'd2);
    chk("frame_a_sum", 16'(out_sum), 16'd4);
    tick();
    for (int i = 0; i < 4; i++) send(4'd15, 4'd0);
    chk("frame_b_val", 16'(out_val), 16'd1);
    chk("frame_b_sum", 16'(out_sum), 16'd60);
    tick();
    // wrap or saturate in the 5-bit instance: 4 x 15 = 60
    for (int i = 0; i < 4; i++) send(4'd0, 4'd15);
    chk("wide_sum", 16'(out_sum), 16'd60);
    chk("narrow_val", 16'(out_val5), 16'd1);
`ifdef SAD_ACCUM_SATURATE_EN
    chk("narrow_sat", 16'(out_sum5), 16'd31);
    chk("narrow_ovf", 16'(ovf5), 16'd1);
    chk("wide_ovf", 16'(ovf), 16'd0);
    tick();
    chk("narrow_ovf_clr", 16'(ovf5), 16'd0);
`else
    chk("narrow_wrap", 16'(out_sum5), 16'd28);
    tick();
`endif
    chk("narrow_cleared", 16'(out_sum5), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
